// File: rtl/lift53_pkg.sv
// Shared constants and helpers for the LeGall 5/3 lifting pipeline.
package lift53_pkg;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    // Internal width: two lifting additions plus rounding need three guard bits.
    function automatic int lift_iw(input int data_w);
        return data_w + 3;
    endfunction

    function automatic logic signed [63:0] lift_floor_shr(input logic signed [63:0] v,
                                                         input int k);
        return v >>> k;
    endfunction

endpackage

// File: rtl/lift53_term.sv
// One lifting term: y = x_mid +/- floor((p + q + rnd) / 2^k), k in {1,2}, rnd in {0,2}.
module lift53_term
    import lift53_pkg::*;
#(
    parameter int IW = 14
) (
    input  logic signed [IW-1:0] x_mid,
    input  logic signed [IW-1:0] p,
    input  logic signed [IW-1:0] q,
    input  logic                 k2,
    input  logic                 add_rnd,
    input  logic                 sub,
    output logic signed [IW-1:0] y
);

    logic signed [IW-1:0] sum;
    logic signed [IW-1:0] fl;

    assign sum = p + q + (add_rnd ? IW'(2) : IW'(0));
    assign fl  = IW'(lift_floor_shr(64'(sum), k2 ? 2 : 1));
    assign y   = sub ? (x_mid - fl) : (x_mid + fl);

endmodule

// File: rtl/lift53_pipe.sv
// Three-stage LeGall 5/3 forward/inverse lifting engine with valid/ready flow control.
// Optional whole-sample symmetric boundary extension when LIFT_SYMEXT_EN is defined.
module lift53_pipe
    import lift53_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int OUT_W  = 36
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    inv,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    input  logic signed [DATA_W-1:0] x4,
    input  logic signed [DATA_W-1:0] x5,
    input  logic                    in_first,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] d3,
    output logic signed [OUT_W-1:0] a2
);

    localparam int IW = lift_iw(DATA_W);

    generate
        if (OUT_W < IW) begin : g_bad_out_w
            $error("lift53_pipe: OUT_W must be at least DATA_W+3");
        end
    endgenerate

    logic en;
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    logic signed [IW-1:0] e1, e2, e3, e4, e5;
    logic signed [IW-1:0] s1, s2, s4, s5;
    assign e1 = IW'(x1);
    assign e2 = IW'(x2);
    assign e3 = IW'(x3);
    assign e4 = IW'(x4);
    assign e5 = IW'(x5);

`ifdef LIFT_SYMEXT_EN
    // Both mirrors read the original samples, so first&last collapses around x3.
    assign s1 = in_first ? e5 : e1;
    assign s2 = in_first ? e4 : e2;
    assign s4 = in_last  ? e2 : e4;
    assign s5 = in_last  ? e1 : e5;
`else
    logic unused_bnd;
    assign unused_bnd = in_first | in_last;
    assign s1 = e1;
    assign s2 = e2;
    assign s4 = e4;
    assign s5 = e5;
`endif

    logic signed [IW-1:0]    w1_p1, w2_p1, w3_p1, w4_p1, w5_p1;
    logic                    inv_p1, vld_p1;
    logic signed [IW-1:0]    tl_p2, tr_p2, x3_p2;
    logic                    inv_p2, vld_p2;
    logic signed [OUT_W-1:0] d3_p3, a2_p3;
    logic                    vld_p3;

    // Stage 2: forward predicts with (p+q)/2, inverse undoes update with (p+q+2)/4.
    logic signed [IW-1:0] tl, tr, tf;
    lift53_term #(.IW(IW)) u_term_left (
        .x_mid(w2_p1), .p(w1_p1), .q(w3_p1),
        .k2(inv_p1 == MODE_INV), .add_rnd(inv_p1 == MODE_INV), .sub(1'b1), .y(tl)
    );
    lift53_term #(.IW(IW)) u_term_right (
        .x_mid(w4_p1), .p(w3_p1), .q(w5_p1),
        .k2(inv_p1 == MODE_INV), .add_rnd(inv_p1 == MODE_INV), .sub(1'b1), .y(tr)
    );

    // Stage 3: forward updates with (p+q+2)/4, inverse predicts with (p+q)/2.
    lift53_term #(.IW(IW)) u_term_final (
        .x_mid(x3_p2), .p(tl_p2), .q(tr_p2),
        .k2(inv_p2 == MODE_FWD), .add_rnd(inv_p2 == MODE_FWD), .sub(1'b0), .y(tf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            inv_p1 <= MODE_FWD;
            inv_p2 <= MODE_FWD;
            w1_p1  <= '0;
            w2_p1  <= '0;
            w3_p1  <= '0;
            w4_p1  <= '0;
            w5_p1  <= '0;
            tl_p2  <= '0;
            tr_p2  <= '0;
            x3_p2  <= '0;
            d3_p3  <= '0;
            a2_p3  <= '0;
        end else if (en) begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            if (in_valid) begin
                w1_p1  <= s1;
                w2_p1  <= s2;
                w3_p1  <= e3;
                w4_p1  <= s4;
                w5_p1  <= s5;
                inv_p1 <= inv;
            end
            if (vld_p1) begin
                tl_p2  <= tl;
                tr_p2  <= tr;
                x3_p2  <= w3_p1;
                inv_p2 <= inv_p1;
            end
            if (vld_p2) begin
                d3_p3 <= OUT_W'((inv_p2 == MODE_INV) ? tf : tr_p2);
                a2_p3 <= OUT_W'((inv_p2 == MODE_INV) ? tl_p2 : tf);
            end
        end
    end

    assign out_valid = vld_p3;
    assign d3        = d3_p3;
    assign a2        = a2_p3;

endmodule

// File: tb/tb_lift53_pipe.sv
// Scoreboard bench for lift53_pipe: directed vectors, mixed-mode streaming, stall and reset.
module tb_lift53_pipe;

    localparam int DATA_W = 11;
    localparam int OUT_W  = 36;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid, in_ready, inv, in_first, in_last;
    logic signed [DATA_W-1:0] x1, x2, x3, x4, x5;
    logic                     out_valid, out_ready;
    logic signed [OUT_W-1:0]  d3, a2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int x1, x2, x3, x4, x5;
        bit inv, first, last;
        int ed3, ea2;
    } beat_t;

    typedef struct {
        logic signed [OUT_W-1:0] d3, a2;
    } exp_t;

    exp_t sb[$];

    lift53_pipe #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inv(inv),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .d3(d3), .a2(a2)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(beat_t b);
        int v1 = b.x1, v2 = b.x2, v3 = b.x3, v4 = b.x4, v5 = b.x5;
        int dl, dr, e0, e1;
        exp_t r;
`ifdef LIFT_SYMEXT_EN
        if (b.first) begin v1 = b.x5; v2 = b.x4; end
        if (b.last)  begin v5 = b.x1; v4 = b.x2; end
`endif
        if (!b.inv) begin
            dl   = v2 - ((v1 + v3) >>> 1);
            dr   = v4 - ((v3 + v5) >>> 1);
            r.d3 = OUT_W'(dr);
            r.a2 = OUT_W'(v3 + ((dl + dr + 2) >>> 2));
        end else begin
            e0   = v2 - ((v1 + v3 + 2) >>> 2);
            e1   = v4 - ((v3 + v5 + 2) >>> 2);
            r.d3 = OUT_W'(v3 + ((e0 + e1) >>> 1));
            r.a2 = OUT_W'(e0);
        end
        return r;
    endfunction

    function automatic exp_t const_exp(beat_t b);
        exp_t r;
        r.d3 = OUT_W'(b.ed3);
        r.a2 = OUT_W'(b.ea2);
        return r;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.x1 = int'($urandom_range(2047, 0)) - 1024;
        b.x2 = int'($urandom_range(2047, 0)) - 1024;
        b.x3 = int'($urandom_range(2047, 0)) - 1024;
        b.x4 = int'($urandom_range(2047, 0)) - 1024;
        b.x5 = int'($urandom_range(2047, 0)) - 1024;
        b.inv   = 1'($urandom_range(1, 0));
        b.first = 1'($urandom_range(1, 0));
        b.last  = 1'($urandom_range(1, 0));
        b.ed3 = 0;
        b.ea2 = 0;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        x1 = DATA_W'(b.x1);
        x2 = DATA_W'(b.x2);
        x3 = DATA_W'(b.x3);
        x4 = DATA_W'(b.x4);
        x5 = DATA_W'(b.x5);
        inv      = b.inv;
        in_first = b.first;
        in_last  = b.last;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; inv = 1'b0; in_first = 1'b0; in_last = 1'b0;
        x1 = '0; x2 = '0; x3 = '0; x4 = '0; x5 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || d3 !== '0 || a2 !== '0) begin
            errors++;
            $display("FAIL reset_state out_valid=%b d3=%0d a2=%0d want 0/0/0", out_valid, d3, a2);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_patterns();
        beat_t rows[$];
        exp_t  e;
        int sent = 0, got = 0, acc0 = -1, out0 = -1;
        rows.push_back('{0, 10, 0, 10, 0, 1'b0, 1'b0, 1'b0, 10, 5});
        rows.push_back('{0, -7, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, -2});
        rows.push_back('{10, 5, 10, 5, 10, 1'b1, 1'b0, 1'b0, 10, 0});
        rows.push_back('{1023, -1024, 1023, -1024, 1023, 1'b0, 1'b0, 1'b0, -2047, 0});
        rows.push_back('{-1024, 1023, -1024, 1023, -1024, 1'b1, 1'b0, 1'b0, 511, 1535});
`ifdef LIFT_SYMEXT_EN
        rows.push_back('{99, 99, 0, 10, 0, 1'b0, 1'b1, 1'b0, 10, 5});
        rows.push_back('{0, 10, 0, 99, 99, 1'b0, 1'b0, 1'b1, 10, 5});
        rows.push_back('{7, 10, 0, 20, 9, 1'b0, 1'b1, 1'b1, 7, 6});
`else
        rows.push_back('{99, 99, 0, 10, 0, 1'b0, 1'b1, 1'b0, 10, 15});
        rows.push_back('{0, 10, 0, 99, 99, 1'b0, 1'b0, 1'b1, 50, 15});
        rows.push_back('{7, 10, 0, 20, 9, 1'b0, 1'b1, 1'b1, 16, 6});
`endif
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && (sent < rows.size() || sb.size() > 0); cyc++) begin
            in_valid = (sent < rows.size());
            if (in_valid) drive(rows[sent]);
            #1;
            if (out_valid && out_ready) begin
                if (out0 < 0) out0 = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pattern_extra d3=%0d a2=%0d want no output", d3, a2);
                end else begin
                    e = sb.pop_front();
                    if (d3 !== e.d3 || a2 !== e.a2) begin
                        errors++;
                        $display("FAIL pattern_%0d d3=%0d a2=%0d want d3=%0d a2=%0d",
                                 got, d3, a2, e.d3, e.a2);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                if (acc0 < 0) acc0 = cyc;
                sb.push_back(const_exp(rows[sent]));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out0 - acc0 != 3) begin
            errors++;
            $display("FAIL latency got=%0d want=3", out0 - acc0);
        end
        checks++;
        if (sent != rows.size() || sb.size() != 0) begin
            errors++;
            $display("FAIL pattern_timeout sent=%0d pending=%0d want all done", sent, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 24;
        beat_t bs[N];
        exp_t  e;
        int sent = 0, got = 0, bubbles = 0, stalls_in = 0, cycles = 0;
        for (int i = 0; i < N; i++) bs[i] = rand_beat();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && (sent < N || sb.size() > 0); cyc++) begin
            in_valid = (sent < N);
            if (in_valid) drive(bs[sent]);
            #1;
            if (!in_ready) stalls_in++;
            if (got > 0 && got < N && !out_valid) bubbles++;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra d3=%0d a2=%0d want no output", d3, a2);
                end else begin
                    e = sb.pop_front();
                    if (d3 !== e.d3 || a2 !== e.a2) begin
                        errors++;
                        $display("FAIL b2b_%0d d3=%0d a2=%0d want d3=%0d a2=%0d",
                                 got, d3, a2, e.d3, e.a2);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(bs[sent]));
                sent++;
            end
            cycles++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (bubbles != 0 || stalls_in != 0 || got != N || cycles != N + 3) begin
            errors++;
            $display("FAIL b2b_throughput bubbles=%0d in_stalls=%0d got=%0d cycles=%0d want 0/0/%0d/%0d",
                     bubbles, stalls_in, got, cycles, N, N + 3);
        end
    endtask

    task automatic test_stall();
        beat_t bs[5];
        exp_t  e;
        int sent = 0, got = 0, stall = 0;
        logic signed [OUT_W-1:0] hd3, ha2;
        hd3 = '0;
        ha2 = '0;
        for (int i = 0; i < 5; i++) bs[i] = rand_beat();
        for (int cyc = 0; cyc < 60 && (sent < 5 || sb.size() > 0); cyc++) begin
            in_valid = (sent < 5);
            if (in_valid) drive(bs[sent]);
            out_ready = (stall == 0);
            #1;
            if (stall > 0) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready got=%b want=0", in_ready);
                end
                if (stall == 4) begin
                    hd3 = d3;
                    ha2 = a2;
                    checks++;
                    if (out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_valid got=%b want=1", out_valid);
                    end
                end else begin
                    checks++;
                    if (d3 !== hd3 || a2 !== ha2 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_hold d3=%0d a2=%0d vld=%b want d3=%0d a2=%0d vld=1",
                                 d3, a2, out_valid, hd3, ha2);
                    end
                end
                stall--;
            end else if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stall_extra d3=%0d a2=%0d want no output", d3, a2);
                end else begin
                    e = sb.pop_front();
                    if (d3 !== e.d3 || a2 !== e.a2) begin
                        errors++;
                        $display("FAIL stall_out_%0d d3=%0d a2=%0d want d3=%0d a2=%0d",
                                 got, d3, a2, e.d3, e.a2);
                    end
                end
                got++;
                if (got == 1) stall = 4;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(bs[sent]));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 5 || sb.size() != 0) begin
            errors++;
            $display("FAIL stall_count got=%0d pending=%0d want 5/0", got, sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        beat_t pre, post;
        exp_t  e;
        int sent = 0, got = 0;
        pre  = '{0, 10, 0, 10, 0, 1'b0, 1'b0, 1'b0, 10, 5};
        post = '{0, -7, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, -2};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(pre);
        repeat (3) begin
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || d3 !== OUT_W'(10)) begin
            errors++;
            $display("FAIL midrst_fill out_valid=%b d3=%0d want 1/10", out_valid, d3);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || d3 !== '0 || a2 !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_clear out_valid=%b d3=%0d a2=%0d in_ready=%b want 0/0/0/1",
                     out_valid, d3, a2, in_ready);
        end
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            in_valid = (sent < 1);
            if (in_valid) drive(post);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL midrst_stale d3=%0d a2=%0d want no output", d3, a2);
                end else begin
                    e = sb.pop_front();
                    if (d3 !== e.d3 || a2 !== e.a2) begin
                        errors++;
                        $display("FAIL midrst_post d3=%0d a2=%0d want d3=%0d a2=%0d",
                                 d3, a2, e.d3, e.a2);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(const_exp(post));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 1) begin
            errors++;
            $display("FAIL midrst_count got=%0d want=1", got);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_patterns();
        test_back_to_back();
        test_stall();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
